// File: rtl/kij_sequencer.sv
// Instruction sequencer for core: walks weight load, activation load, execute, drain, writeback per kij.
// Latency: start sampled at edge N, first WL0 instruction visible after edge N+1; all outputs registered.
// Backpressure: ORD stalls on ofifo_valid=0 (read count holds); no other flow control.
//
// Ports: clk, reset (sync, active-low); start (honoured in IDLE only); ofifo_valid (core OFIFO readable);
//        inst (34-bit core instruction word); kij (current kernel index); busy (not IDLE); done (end-of-run pulse).
module kij_sequencer #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_nij = 36,
    parameter int len_kij = 9,
    parameter int gap     = 10,
    parameter int wbase   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic [3:0]  kij,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] st_idle  = 4'd0;
    localparam logic [3:0] st_wl0   = 4'd1;
    localparam logic [3:0] st_g1    = 4'd2;
    localparam logic [3:0] st_wload = 4'd3;
    localparam logic [3:0] st_g2    = 4'd4;
    localparam logic [3:0] st_al0   = 4'd5;
    localparam logic [3:0] st_g3    = 4'd6;
    localparam logic [3:0] st_exec  = 4'd7;
    localparam logic [3:0] st_drain = 4'd8;
    localparam logic [3:0] st_ord   = 4'd9;
    localparam logic [3:0] st_g4    = 4'd10;
    localparam logic [3:0] st_done  = 4'd11;

    localparam logic [10:0] col_n      = 11'(col);
    localparam logic [10:0] nij_n      = 11'(len_nij);
    localparam logic [10:0] col_last   = 11'(col - 1);
    localparam logic [10:0] nij_last   = 11'(len_nij - 1);
    localparam logic [10:0] gap_last   = 11'(gap - 1);
    localparam logic [10:0] drain_last = 11'(row + col - 1);
    localparam logic [10:0] wbase_a    = 11'(wbase);
    localparam logic [3:0]  kij_last   = 4'(len_kij - 1);

    // Both SRAMs deselected with write-enable high, everything else quiet.
    localparam logic [33:0] idle_word = 34'h1_800C_0000;

    // The state registers describe the instruction that will be shown after the next edge;
    // inst/kij/busy/done are the registered view of that one cycle later.
    logic [3:0]  state, state_nxt;
    logic [10:0] c, c_nxt;
    logic [3:0]  kij_cnt, kij_nxt;
    logic [10:0] rd_cnt, rd_cnt_nxt;
    logic [10:0] wr_cnt, wr_cnt_nxt;
    logic        rd_pend, rd_pend_nxt;
    logic [33:0] word;
    logic [10:0] w_addr;
    logic [10:0] p_addr;

    assign w_addr = wbase_a + 11'(kij_cnt) * col_n + c;
    assign p_addr = 11'(kij_cnt) * nij_n + wr_cnt;

    always_comb begin
        state_nxt   = state;
        c_nxt       = c + 11'd1;
        kij_nxt     = kij_cnt;
        rd_cnt_nxt  = '0;
        wr_cnt_nxt  = '0;
        rd_pend_nxt = 1'b0;
        word        = idle_word;
        case (state)
            st_idle: begin
                c_nxt = '0;
                if (start) state_nxt = st_wl0;
            end
            st_wl0: begin
                // xmem read data arrives one cycle later, so l0_wr trails the address by one slot.
                if (c < col_n) begin
                    word[19]   = 1'b0;
                    word[17:7] = w_addr;
                end
                if (c != 11'd0) word[2] = 1'b1;
                if (c == col_n) begin
                    state_nxt = st_g1;
                    c_nxt     = '0;
                end
            end
            st_g1: if (c == gap_last) begin state_nxt = st_wload; c_nxt = '0; end
            st_wload: begin
                word[3] = 1'b1;
                word[0] = 1'b1;
                if (c == col_last) begin state_nxt = st_g2; c_nxt = '0; end
            end
            st_g2: if (c == gap_last) begin state_nxt = st_al0; c_nxt = '0; end
            st_al0: begin
                if (c < nij_n) begin
                    word[19]   = 1'b0;
                    word[17:7] = c;
                end
                if (c != 11'd0) word[2] = 1'b1;
                if (c == nij_n) begin state_nxt = st_g3; c_nxt = '0; end
            end
            st_g3: if (c == gap_last) begin state_nxt = st_exec; c_nxt = '0; end
            st_exec: begin
                word[3] = 1'b1;
                word[1] = 1'b1;
                if (c == nij_last) begin state_nxt = st_drain; c_nxt = '0; end
            end
            st_drain: if (c == drain_last) begin state_nxt = st_ord; c_nxt = '0; end
            st_ord: begin
                c_nxt      = '0;
                rd_cnt_nxt = rd_cnt;
                wr_cnt_nxt = wr_cnt;
                if ((rd_cnt < nij_n) && ofifo_valid) begin
                    word[6]     = 1'b1;
                    rd_pend_nxt = 1'b1;
                    rd_cnt_nxt  = rd_cnt + 11'd1;
                end
                // A read issued last cycle turns into a pmem write now.
                if (rd_pend) begin
                    word[32]    = 1'b0;
                    word[31]    = 1'b0;
                    word[30:20] = p_addr;
                    wr_cnt_nxt  = wr_cnt + 11'd1;
                    if (wr_cnt == nij_last) state_nxt = st_g4;
                end
            end
            st_g4: begin
                if (c == gap_last) begin
                    c_nxt = '0;
                    if (kij_cnt == kij_last) begin
                        state_nxt = st_done;
                    end else begin
                        kij_nxt   = kij_cnt + 4'd1;
                        state_nxt = st_wl0;
                    end
                end
            end
            st_done: begin
                c_nxt     = '0;
                kij_nxt   = '0;
                state_nxt = st_idle;
            end
            default: begin
                c_nxt     = '0;
                kij_nxt   = '0;
                state_nxt = st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= st_idle;
            c       <= '0;
            kij_cnt <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            rd_pend <= 1'b0;
            inst    <= idle_word;
            kij     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            c       <= c_nxt;
            kij_cnt <= kij_nxt;
            rd_cnt  <= rd_cnt_nxt;
            wr_cnt  <= wr_cnt_nxt;
            rd_pend <= rd_pend_nxt;
            inst    <= word;
            kij     <= kij_cnt;
            busy    <= (state != st_idle);
            done    <= (state == st_done);
        end
    end

endmodule

// File: doc/kij_sequencer.md
# kij_sequencer

Instruction sequencer that drives the 34-bit `inst` bus of `core`, replacing hand-written bench stimulus. It walks the weight-stationary flow for every kernel position kij: weights xmem→L0, L0→PE load, activations xmem→L0, execute and drain, then OFIFO→pmem writeback. The block sits directly upstream of `core`, and its `inst` output connects to `core.inst`. Activations live at xmem 0..len_nij-1. Weight set kij lives at `wbase + kij*col`. Psums for kij are written to pmem at `kij*len_nij`.

## Interface
- `row`, 8: PE rows.
- `col`, 8: PE columns; weight words per kij.
- `len_nij`, 36: activation words per kij.
- `len_kij`, 9: kernel positions.
- `gap`, 10: idle cycles between phases.
- `wbase`, 1024: xmem base address of weight set 0.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low (0 = reset).
- `start`, input, 1: begin a full len_kij run; sampled in IDLE only.
- `ofifo_valid`, input, 1: `core` OFIFO has a readable word.
- `inst`, output, 34: registered. Field layout:
  - [33] acc
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd
  - [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- `kij`, output, 4: current kernel index.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse at end of run.

## Operation
- **Idle instruction word:** CEN_xmem=WEN_xmem=CEN_pmem=WEN_pmem=1; addresses 0; all other bits 0. acc, ififo_wr and ififo_rd are always 0.
- **Reset:** `inst` takes the idle word; kij=0; busy=0; done=0; state=IDLE. Reset asserted mid-run aborts the run; the idle word appears on the cycle after the reset edge.
- **States (per-phase counter c starts at 0):**
  - IDLE: `start`=1 → WL0.
  - WL0, col+1 cycles:
    - c<col: CEN_xmem=0, WEN_xmem=1, A_xmem=wbase+kij*col+c.
    - l0_wr=1 for c=1..col (one-cycle xmem read latency).
  - G1: gap idle cycles.
  - WLOAD, col cycles: l0_rd=1, load=1.
  - G2: gap idle cycles.
  - AL0, len_nij+1 cycles: xmem read of A_xmem=c for c<len_nij; l0_wr=1 for c=1..len_nij.
  - G3: gap idle cycles.
  - EXEC, len_nij cycles: l0_rd=1, execute=1.
  - DRAIN, row+col idle cycles.
  - ORD: reads len_nij words from the OFIFO.
    - ofifo_rd=ofifo_valid while reads issued < len_nij. Stalls (ofifo_rd=0) while ofifo_valid=0; the read count holds.
    - Every ofifo_rd cycle is followed next cycle by a pmem write: CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+n, n=0..len_nij-1.
    - Exit when the len_nij-th write has been issued.
  - G4: gap idle cycles.
    - kij<len_kij-1: kij+=1, → WL0.
    - Otherwise → DONE.
  - DONE, 1 cycle: done=1, idle word → IDLE. kij returns to 0 on the IDLE entry.
- **Arithmetic:** addresses are 11-bit unsigned. With defaults the maxima are xmem 1024+71=1095 and pmem 8*36+35=323. No wrap is legal. Parameter sets whose addresses would exceed 2047 are unsupported.
- **start:** ignored while busy. A start held high at DONE does not re-launch until IDLE has been entered.

## Timing
- All outputs are registered and change only on rising edges.
- Latency: start sampled at edge N → first WL0 word visible after edge N+1.
- Per-kij length with ofifo_valid held high: 9+10+8+10+37+10+36+16+37+10 = 183 cycles.
- With defaults, done is high during cycle 1+9*183 = 1648 counted from the start edge.
- Each cycle ofifo_valid stays low in ORD adds exactly one cycle.
- l0_wr always lags its xmem address by exactly one cycle.
- The pmem write always lags its ofifo_rd by exactly one cycle.

## Test plan
- **Reset:** hold reset=0 for 3 cycles, then release → inst = idle word (bits 32,31,19,18 set, all other bits 0); busy=0; done=0; kij=0.
- **Single full run,** ofifo_valid=1 →
  - busy rises 1 cycle after start.
  - done pulses exactly at cycle 1648 for one cycle.
  - kij steps 0..8 every 183 cycles.
- **Address check, kij=3:**
  - WL0 emits A_xmem 1048..1055, with l0_wr on the following 8 cycles.
  - ORD emits pmem writes at A_pmem 108..143, one cycle after each ofifo_rd.
- **OFIFO stall:** drop ofifo_valid for 5 cycles mid-ORD at n=10 →
  - ofifo_rd=0 and no pmem write during the stall.
  - Resumes at n=10.
  - Total run is +5 cycles.
- **Reset mid-EXEC of kij=4:** → idle word on the next cycle, kij=0, busy=0. A new start replays from kij=0 with the standard 183-cycle period.
- **start while busy and held through DONE:** no restart mid-run. The new run begins only after one IDLE cycle.
